// File: rtl/imem_fetch_queue.sv
// Instruction fetch sequencer plus DEPTH-entry {pc, instr} prefetch FIFO.
// Optional out-of-range fetch blocking is enabled by defining IMEM_FETCH_BOUNDS_CHECK_EN.
module imem_fetch_queue #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_en,
  output logic [31:0]                iaddr,
  input  logic [31:0]                idata,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       fetch_fault
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   instr_q [DEPTH];
  logic          push;
  logic          pop;
  logic          blocked;

  // Output handshake: the head entry transfers on any edge where out_valid and
  // out_ready are both high; out_valid never depends on out_ready, and out_* hold
  // while out_valid is high and out_ready is low.
  assign out_valid = (count != '0);
  assign out_pc    = pc_q[rd_ptr];
  assign out_instr = instr_q[rd_ptr];
  assign iaddr     = fetch_pc;

  assign pop  = out_valid & out_ready;
  // A full queue may still accept when the head leaves in the same cycle.
  assign push = fetch_en & ~redirect_valid & ((count != FULL) | pop) & ~blocked;

`ifdef IMEM_FETCH_BOUNDS_CHECK_EN
  localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);
  logic oob;
  logic fault_q;

  assign oob         = (fetch_pc[31:2] >= IMEM_LIMIT);
  assign blocked     = oob | fault_q;
  assign fetch_fault = fault_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fault_q <= 1'b0;
    end else if (redirect_valid) begin
      fault_q <= 1'b0;
    end else if (fetch_en && oob) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign blocked     = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      // A pop coincident with the redirect is dropped along with the old path.
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]    <= fetch_pc;
      instr_q[wr_ptr] <= idata;
    end
  end

endmodule
